dma_priority_resolver: RTL and testbench
========================================

DMA_PRIORITY_RESOLVER -- requirements
Module: dma_priority_resolver

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RESET_N  input  1  asynchronous, active-low reset; deassertion is synchronous to CLK.
REQ-003 DREQ  input  4  per-channel DMA request lines, polarity set by dreqSense.
REQ-004 HLDA  input  1  hold acknowledge from CPU, active high.
REQ-005 maskReg  input  4  per-channel mask; 1 = channel ignored.
REQ-006 priorityType  input  1  0 = fixed priority, 1 = rotating priority.
REQ-007 dreqSense  input  1  0 = DREQ active high, 1 = DREQ active low.
REQ-008 cycleDone  input  1  one-cycle pulse from timing-and-control marking end of the granted service.
REQ-009 HRQ  output  1  hold request to CPU, registered.
REQ-010 DACK  output  4  one-hot DMA acknowledge, active high, registered.
REQ-011 grantChannel  output  2  encoded index of the granted channel; valid only while grantValid = 1.
REQ-012 grantValid  output  1  high exactly while DACK is non-zero.
REQ-013 priorityOrder  output  8  four 2-bit channel fields; [1:0] = highest-priority channel, [7:6] = lowest.

Function
REQ-014 Effective request: req = (DREQ ^ {4{dreqSense}}) & ~maskReg, combinational.
REQ-015 FSM states: IDLE, REQ, GRANT, RELEASE, one-hot encoded.
REQ-016 IDLE -> REQ on any edge where req != 0; HRQ = 1 from that edge onward.
REQ-017 REQ, HLDA = 1, req != 0 -> GRANT; winner = first channel in priorityOrder order ([1:0] first) with req bit set; DACK = onehot(winner) and grantChannel = winner on the same edge.
REQ-018 REQ, req == 0 (request withdrawn before HLDA) -> IDLE; HRQ = 0 on that edge; no DACK.
REQ-019 REQ, HLDA = 0, req != 0 -> stay in REQ with HRQ held at 1.
REQ-020 GRANT: DACK, grantChannel and HRQ hold; changes on DREQ or maskReg do not alter the grant.
REQ-021 GRANT, cycleDone = 1 -> RELEASE; DACK = 0 and HRQ = 0 on that edge; rotation per REQ-024.
REQ-022 GRANT, HLDA = 0 and cycleDone = 0 (abort) -> IDLE; DACK = 0 and HRQ = 0 on that edge; priorityOrder unchanged.
REQ-023 RELEASE -> IDLE unconditionally after one cycle; HRQ = 0 and DACK = 0; new requests are evaluated only from IDLE.
REQ-024 Rotating mode: on completion of channel n, priorityOrder becomes {n, n+3, n+2, n+1} (mod 4, MSB field first), so the serviced channel is lowest priority.
REQ-025 Fixed mode: priorityOrder forced to 8'b11_10_01_00 on every edge where priorityType = 0.
REQ-026 Simultaneous cycleDone and HLDA fall in GRANT: treat as completion (REQ-021).
REQ-027 Latency: request sampled at edge k gives HRQ after edge k; HLDA sampled at edge m gives DACK after edge m; minimum DREQ-to-DACK is 2 edges.
REQ-028 DACK is always one-hot or zero; grantValid = |DACK.

Reset
REQ-029 While RESET_N = 0: state = IDLE, HRQ = 0, DACK = 4'b0000, grantValid = 0, grantChannel = 2'b00, priorityOrder = 8'b11_10_01_00.
REQ-030 Reset asserted mid-GRANT clears DACK and HRQ immediately, without waiting for a clock edge.
REQ-031 After RESET_N rises, the first arbitration uses the default priorityOrder.

Verification
REQ-032 Fixed priority, dreqSense = 0, mask = 0, DREQ = 4'b0011, HLDA = 1 -> HRQ after 1 edge, DACK = 4'b0001 after 2 edges, grantChannel = 0.
REQ-033 Fixed priority, DREQ = 4'b1110 -> DACK = 4'b0010; after cycleDone, 1 RELEASE cycle with DACK = 0, then a new request is accepted.
REQ-034 Rotating priority, DREQ = 4'b1111, service ch0 -> priorityOrder = 8'b00_11_10_01; next grant DACK = 4'b0010.
REQ-035 maskReg = 4'b0001, DREQ = 4'b0001 -> HRQ stays 0; dreqSense = 1 with DREQ = 4'b1011 -> DACK = 4'b0100.
REQ-036 HLDA dropped in GRANT without cycleDone -> DACK = 0 and HRQ = 0 next edge, priorityOrder unchanged; request withdrawn in REQ -> IDLE, no DACK.
REQ-037 RESET_N pulsed low mid-GRANT -> DACK = 0 and HRQ = 0 asynchronously, priorityOrder = 8'b11_10_01_00.

Source files
------------

// File: rtl/dma_priority_resolver_if.sv
// Request/grant bundle between DMA channel logic, CPU hold handshake and
// the priority resolver.
interface dma_priority_resolver_if;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       dreqSense;
  logic       cycleDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] grantChannel;
  logic       grantValid;
  logic [7:0] priorityOrder;

  modport slave (
    input  DREQ, HLDA, maskReg, priorityType, dreqSense, cycleDone,
    output HRQ, DACK, grantChannel, grantValid, priorityOrder
  );

  modport master (
    output DREQ, HLDA, maskReg, priorityType, dreqSense, cycleDone,
    input  HRQ, DACK, grantChannel, grantValid, priorityOrder
  );
endinterface

// File: rtl/dma_priority_resolver.sv
// Four-channel DMA priority resolver: HRQ/HLDA hold handshake, fixed or
// rotating priority, one-hot registered DACK.
module dma_priority_resolver (
  input  logic                     CLK,
  input  logic                     RESET_N,
  dma_priority_resolver_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    GRANT   = 4'b0100,
    RELEASE = 4'b1000
  } state_t;

  localparam logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00;

  state_t     state, state_nxt;
  logic       hrq, hrq_nxt;
  logic [3:0] dack, dack_nxt;
  logic [1:0] grant_ch, grant_ch_nxt;
  logic [7:0] prio_order, prio_order_nxt;
  logic [3:0] req;
  logic [1:0] winner;

  // First channel in priority order (field [1:0] first) with its request set.
  function automatic logic [1:0] pick_winner(input logic [7:0] order,
                                             input logic [3:0] r);
    logic [1:0] pick;
    pick = order[1:0];
    for (int i = 3; i >= 0; i--) begin
      if (r[order[2*i +: 2]]) pick = order[2*i +: 2];
    end
    return pick;
  endfunction

  // The serviced channel drops to the lowest slot; its successor becomes highest.
  function automatic logic [7:0] rotate_order(input logic [1:0] n);
    return {n, n + 2'd3, n + 2'd2, n + 2'd1};
  endfunction

  assign req    = (bus.DREQ ^ {4{bus.dreqSense}}) & ~bus.maskReg;
  assign winner = pick_winner(prio_order, req);

  always_comb begin
    state_nxt      = state;
    hrq_nxt        = hrq;
    dack_nxt       = dack;
    grant_ch_nxt   = grant_ch;
    prio_order_nxt = prio_order;

    unique case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_nxt = REQ;
          hrq_nxt   = 1'b1;
        end
      end
      REQ: begin
        if (req == 4'b0000) begin
          state_nxt = IDLE;
          hrq_nxt   = 1'b0;
        end else if (bus.HLDA) begin
          state_nxt    = GRANT;
          dack_nxt     = 4'b0001 << winner;
          grant_ch_nxt = winner;
        end
      end
      GRANT: begin
        // Completion takes precedence over a simultaneous HLDA drop.
        if (bus.cycleDone) begin
          state_nxt      = RELEASE;
          hrq_nxt        = 1'b0;
          dack_nxt       = 4'b0000;
          prio_order_nxt = rotate_order(grant_ch);
        end else if (!bus.HLDA) begin
          state_nxt = IDLE;
          hrq_nxt   = 1'b0;
          dack_nxt  = 4'b0000;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        hrq_nxt   = 1'b0;
        dack_nxt  = 4'b0000;
      end
      default: begin
        state_nxt = IDLE;
        hrq_nxt   = 1'b0;
        dack_nxt  = 4'b0000;
      end
    endcase

    if (!bus.priorityType) prio_order_nxt = DEFAULT_ORDER;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      hrq        <= 1'b0;
      dack       <= 4'b0000;
      grant_ch   <= 2'b00;
      prio_order <= DEFAULT_ORDER;
    end else begin
      state      <= state_nxt;
      hrq        <= hrq_nxt;
      dack       <= dack_nxt;
      grant_ch   <= grant_ch_nxt;
      prio_order <= prio_order_nxt;
    end
  end

  assign bus.HRQ           = hrq;
  assign bus.DACK          = dack;
  assign bus.grantChannel  = grant_ch;
  assign bus.grantValid    = |dack;
  assign bus.priorityOrder = prio_order;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed-vector bench for dma_priority_resolver.
module tb_dma_priority_resolver;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  dma_priority_resolver_if bus ();

  dma_priority_resolver dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n            = 1'b0;
    bus.DREQ         = 4'b0000;
    bus.HLDA         = 1'b0;
    bus.maskReg      = 4'b0000;
    bus.priorityType = 1'b0;
    bus.dreqSense    = 1'b0;
    bus.cycleDone    = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_hrq",   {31'd0, bus.HRQ}, 32'd0);
    chk("rst_dack",  {28'd0, bus.DACK}, 32'd0);
    chk("rst_gv",    {31'd0, bus.grantValid}, 32'd0);
    chk("rst_gch",   {30'd0, bus.grantChannel}, 32'd0);
    chk("rst_order", {24'd0, bus.priorityOrder}, 32'hE4);
    rst_n = 1'b1;
    step();

    // Fixed priority, DREQ=0011, HLDA already high
    bus.DREQ = 4'b0011;
    bus.HLDA = 1'b1;
    step();
    chk("fx_hrq1",  {31'd0, bus.HRQ}, 32'd1);
    chk("fx_dack1", {28'd0, bus.DACK}, 32'd0);
    step();
    chk("fx_dack2", {28'd0, bus.DACK}, 32'h1);
    chk("fx_gch",   {30'd0, bus.grantChannel}, 32'd0);
    chk("fx_gv",    {31'd0, bus.grantValid}, 32'd1);
    bus.DREQ    = 4'b1000;
    bus.maskReg = 4'b0001;
    step();
    chk("fx_hold",  {28'd0, bus.DACK}, 32'h1);
    chk("fx_holdh", {31'd0, bus.HRQ}, 32'd1);
    bus.maskReg   = 4'b0000;
    bus.cycleDone = 1'b1;
    step();
    chk("fx_done_dack", {28'd0, bus.DACK}, 32'd0);
    chk("fx_done_hrq",  {31'd0, bus.HRQ}, 32'd0);
    bus.cycleDone = 1'b0;
    bus.DREQ      = 4'b0000;
    step();

    // Fixed priority, DREQ=1110 -> ch1, release, then re-accept
    bus.DREQ = 4'b1110;
    step();
    chk("f2_hrq", {31'd0, bus.HRQ}, 32'd1);
    step();
    chk("f2_dack", {28'd0, bus.DACK}, 32'h2);
    chk("f2_gch",  {30'd0, bus.grantChannel}, 32'd1);
    bus.cycleDone = 1'b1;
    step();
    chk("f2_rel_dack", {28'd0, bus.DACK}, 32'd0);
    chk("f2_rel_hrq",  {31'd0, bus.HRQ}, 32'd0);
    bus.cycleDone = 1'b0;
    step();
    chk("f2_idle_hrq", {31'd0, bus.HRQ}, 32'd0);
    step();
    chk("f2_reacc_hrq", {31'd0, bus.HRQ}, 32'd1);
    step();
    chk("f2_reacc_dack", {28'd0, bus.DACK}, 32'h2);
    bus.HLDA = 1'b0;
    step();
    chk("f2_abort_dack", {28'd0, bus.DACK}, 32'd0);
    chk("f2_abort_hrq",  {31'd0, bus.HRQ}, 32'd0);
    bus.DREQ = 4'b0000;
    step();

    // Rotating priority, all channels requesting
    bus.priorityType = 1'b1;
    bus.DREQ         = 4'b1111;
    bus.HLDA         = 1'b1;
    step();
    step();
    chk("rot_dack0", {28'd0, bus.DACK}, 32'h1);
    bus.cycleDone = 1'b1;
    bus.HLDA      = 1'b0;
    step();
    chk("rot_order", {24'd0, bus.priorityOrder}, 32'h39);
    chk("rot_rel",   {28'd0, bus.DACK}, 32'd0);
    bus.cycleDone = 1'b0;
    bus.HLDA      = 1'b1;
    step();
    step();
    chk("rot_hrq", {31'd0, bus.HRQ}, 32'd1);
    step();
    chk("rot_dack1", {28'd0, bus.DACK}, 32'h2);
    chk("rot_gch1",  {30'd0, bus.grantChannel}, 32'd1);
    bus.HLDA = 1'b0;
    step();
    chk("rot_abort_dack",  {28'd0, bus.DACK}, 32'd0);
    chk("rot_abort_hrq",   {31'd0, bus.HRQ}, 32'd0);
    chk("rot_abort_order", {24'd0, bus.priorityOrder}, 32'h39);
    step();
    chk("wd_hrq", {31'd0, bus.HRQ}, 32'd1);
    bus.DREQ = 4'b0000;
    step();
    chk("wd_idle_hrq",  {31'd0, bus.HRQ}, 32'd0);
    chk("wd_idle_dack", {28'd0, bus.DACK}, 32'd0);
    bus.priorityType = 1'b0;
    step();
    chk("fx_force_order", {24'd0, bus.priorityOrder}, 32'hE4);

    // Masking and active-low sense
    bus.maskReg = 4'b0001;
    bus.DREQ    = 4'b0001;
    bus.HLDA    = 1'b1;
    step();
    step();
    chk("mask_hrq", {31'd0, bus.HRQ}, 32'd0);
    bus.maskReg   = 4'b0000;
    bus.dreqSense = 1'b1;
    bus.DREQ      = 4'b1011;
    step();
    chk("low_hrq", {31'd0, bus.HRQ}, 32'd1);
    step();
    chk("low_dack", {28'd0, bus.DACK}, 32'h4);
    chk("low_gch",  {30'd0, bus.grantChannel}, 32'd2);

    // Rotate after ch2, regrant ch2 from the new order, then async reset
    bus.priorityType = 1'b1;
    bus.cycleDone    = 1'b1;
    step();
    chk("rot2_order", {24'd0, bus.priorityOrder}, 32'h93);
    bus.cycleDone = 1'b0;
    step();
    step();
    step();
    chk("rot2_dack", {28'd0, bus.DACK}, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dack",  {28'd0, bus.DACK}, 32'd0);
    chk("arst_hrq",   {31'd0, bus.HRQ}, 32'd0);
    chk("arst_gv",    {31'd0, bus.grantValid}, 32'd0);
    chk("arst_order", {24'd0, bus.priorityOrder}, 32'hE4);
    step();
    rst_n         = 1'b1;
    bus.dreqSense = 1'b0;
    bus.DREQ      = 4'b1111;
    step();
    step();
    chk("post_rst_dack", {28'd0, bus.DACK}, 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
